// File: rtl/cla_adder16_pkg.sv
// cla_adder16_pkg: shared width constants for the 16-bit carry-lookahead adder
package cla_adder16_pkg;
  localparam int ADDER_WIDTH = 16;
  localparam int GROUP_WIDTH = 4;
  localparam int NUM_GROUPS  = 4;
endpackage

// File: rtl/cla_adder16_cla4.sv
// cla4_block: 4-bit lookahead group producing sum, group propagate and group generate
module cla4_block
  import cla_adder16_pkg::*;
(
  input  logic [GROUP_WIDTH-1:0] a,
  input  logic [GROUP_WIDTH-1:0] b,
  input  logic                   cin,
  output logic [GROUP_WIDTH-1:0] sum,
  output logic                   p,
  output logic                   g
);
  logic [GROUP_WIDTH-1:0] bp, bg, c;
  // per-bit propagate/generate, in-group carries, and group P/G
  always_comb begin
    bp   = a ^ b;
    bg   = a & b;
    c[0] = cin;
    c[1] = bg[0] | (bp[0] & cin);
    c[2] = bg[1] | (bp[1] & bg[0]) | (bp[1] & bp[0] & cin);
    c[3] = bg[2] | (bp[2] & bg[1]) | (bp[2] & bp[1] & bg[0]) | (bp[2] & bp[1] & bp[0] & cin);
    sum  = bp ^ c;
    p    = &bp;
    g    = bg[3] | (bp[3] & bg[2]) | (bp[3] & bp[2] & bg[1]) | (bp[3] & bp[2] & bp[1] & bg[0]);
  end
endmodule

// File: rtl/cla_adder16.sv
// cla_adder16: two-level carry-lookahead 16-bit adder with registered sum and carry out
module cla_adder16
  import cla_adder16_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst,
  output logic [ADDER_WIDTH-1:0] sum,
  output logic                   carry_out,
  input  logic [ADDER_WIDTH-1:0] a,
  input  logic [ADDER_WIDTH-1:0] b,
  input  logic                   carry_in
);
  logic [NUM_GROUPS-1:0]  gp, gg;
  logic [NUM_GROUPS:0]    gc;
  logic [ADDER_WIDTH-1:0] s;
  for (genvar i = 0; i < NUM_GROUPS; i++) begin : g_grp
    cla4_block u_blk (
      .a   (a[i*GROUP_WIDTH +: GROUP_WIDTH]),
      .b   (b[i*GROUP_WIDTH +: GROUP_WIDTH]),
      .cin (gc[i]),
      .sum (s[i*GROUP_WIDTH +: GROUP_WIDTH]),
      .p   (gp[i]),
      .g   (gg[i])
    );
  end
  // second-level lookahead: group carries c4..c16 straight from G, P and carry_in
  always_comb begin
    gc[0] = carry_in;
    gc[1] = gg[0] | (gp[0] & carry_in);
    gc[2] = gg[1] | (gp[1] & gg[0]) | (gp[1] & gp[0] & carry_in);
    gc[3] = gg[2] | (gp[2] & gg[1]) | (gp[2] & gp[1] & gg[0]) | (gp[2] & gp[1] & gp[0] & carry_in);
    gc[4] = gg[3] | (gp[3] & gg[2]) | (gp[3] & gp[2] & gg[1]) | (gp[3] & gp[2] & gp[1] & gg[0])
          | (gp[3] & gp[2] & gp[1] & gp[0] & carry_in);
  end
  // output register; reset forces a zero result on that edge only
  always_ff @(posedge clk) begin
    if (rst) {carry_out, sum} <= '0;
    else     {carry_out, sum} <= {gc[4], s};
  end
endmodule

// File: tb/tb_cla_adder16.sv
// tb_cla_adder16: random and directed checks of cla_adder16 against an arithmetic reference
module tb_cla_adder16;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] a = '0, b = '0;
  logic        carry_in = 1'b0;
  logic [15:0] sum;
  logic        carry_out;
  logic        lit_on = 1'b0;
  logic [16:0] lit_exp = '0;
  int          total = 0, bad = 0;

  cla_adder16 dut (
    .clk       (clk),
    .rst       (rst),
    .sum       (sum),
    .carry_out (carry_out),
    .a         (a),
    .b         (b),
    .carry_in  (carry_in)
  );

  always #5 clk = ~clk;

  // reference: result of the inputs at each edge appears just after that edge
  initial begin
    logic [16:0] e, le, got;
    logic        lo;
    logic [15:0] sa, sb;
    logic        sc, sr;
    forever begin
      @(posedge clk);
      sa = a; sb = b; sc = carry_in; sr = rst;
      e  = sr ? 17'd0 : 17'(sa) + 17'(sb) + 17'(sc);
      le = lit_exp;
      lo = lit_on;
      #1;
      got = {carry_out, sum};
      total++;
      if (got !== e) begin
        bad++;
        $display("FAIL model rst=%0b a=%h b=%h cin=%0b got=%h exp=%h", sr, sa, sb, sc, got, e);
      end
      if (lo) begin
        total++;
        if (got !== le) begin
          bad++;
          $display("FAIL literal rst=%0b a=%h b=%h cin=%0b got=%h exp=%h", sr, sa, sb, sc, got, le);
        end
      end
    end
  end

  task automatic vec(input logic [15:0] va, input logic [15:0] vb, input logic vc,
                     input logic vr, input logic [16:0] ve);
    @(negedge clk);
    a = va; b = vb; carry_in = vc; rst = vr;
    lit_on = 1'b1; lit_exp = ve;
  endtask

  initial begin
    vec(16'h1234, 16'h4321, 1'b1, 1'b1, 17'h00000);
    vec(16'hFFFF, 16'hFFFF, 1'b1, 1'b1, 17'h00000);
    vec(16'd10,    16'd22,    1'b0, 1'b0, 17'd32);
    vec(16'd10,    16'd22,    1'b1, 1'b0, 17'd33);
    vec(16'd32768, 16'd65535, 1'b0, 1'b0, 17'h17FFF);
    vec(16'd32768, 16'd32768, 1'b0, 1'b0, 17'h10000);
    vec(16'd32767, 16'd32767, 1'b1, 1'b0, 17'h0FFFF);
    vec(16'd65535, 16'd65535, 1'b0, 1'b0, 17'h1FFFE);
    vec(16'd0,     16'd0,     1'b0, 1'b0, 17'h00000);
    vec(16'hFFFF,  16'h0000,  1'b1, 1'b0, 17'h10000);
    vec(16'hFFFF,  16'h0000,  1'b0, 1'b0, 17'h0FFFF);
    vec(16'hAAAA,  16'h5555,  1'b1, 1'b0, 17'h10000);
    vec(16'h5555,  16'hAAAA,  1'b0, 1'b0, 17'h0FFFF);
    vec(16'h00FF,  16'hFF00,  1'b1, 1'b0, 17'h10000);
    vec(16'hFFFF,  16'hFFFF,  1'b1, 1'b1, 17'h00000);
    vec(16'hFFFF,  16'hFFFF,  1'b1, 1'b0, 17'h1FFFF);
    vec(16'h0F0F,  16'h00F1,  1'b0, 1'b0, 17'h01000);
    for (int i = 0; i < 12000; i++) begin
      @(negedge clk);
      lit_on   = 1'b0;
      a        = 16'($urandom);
      b        = 16'($urandom);
      carry_in = 1'($urandom);
      rst      = ($urandom_range(63) == 0);
    end
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #2;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
